// File: rtl/alu_pkg.sv
// Shared types and widths for the riscv-mini execute-stage ALU.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int IMM_W  = 6;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_INV = 4'd2,
    ALU_SLL = 4'd3,
    ALU_SRL = 4'd4,
    ALU_AND = 4'd5,
    ALU_OR  = 4'd6,
    ALU_SLT = 4'd7,
    ALU_MUL = 4'd8
  } alu_func_e;

  typedef enum logic [2:0] {
    OP_REG   = 3'd0,
    OP_IMM   = 3'd1,
    OP_ADDR  = 3'd2,
    OP_UPPER = 3'd3
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_flags.sv
// Z/N/C/V status register: loads flags_nxt on a rising clk when flag_we, else holds.
// One-cycle capture latency, no backpressure; rst clears all flags asynchronously.
module alu_flags
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flag_we,
  input  alu_flags_t flags_nxt,
  output alu_flags_t flags_o
);

  alu_flags_t flags_d;
  alu_flags_t flags_q;

  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      flags_d = flags_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/alu.sv
// 16-bit combinational ALU (zero latency, no backpressure) with registered Z/N/C/V flags.
// Define ALU_MUL_EN to make func4=8 a low-half multiply; otherwise it returns 0.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [IMM_W-1:0]  imm,
  input  logic [2:0]        op,
  input  logic [3:0]        func4,
  output logic [DATA_W-1:0] alu_o,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v
);

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W:0]   add_full;
  logic [DATA_W-1:0] sub_res;
  logic              add_v;
  logic              sub_v;
  logic              sub_borrow;
  logic [DATA_W-1:0] res;
  logic              res_c;
  logic              res_v;
  alu_flags_t        flags_nxt;
  alu_flags_t        flags_cur;

  assign a        = rs1_data;
  assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign b        = (op == OP_IMM || op == OP_ADDR) ? imm_sext : rs2_data;

  // Shared adder/subtractor; overflow when the result sign disagrees with A under matching effective signs.
  assign add_full   = {1'b0, a} + {1'b0, b};
  assign sub_res    = a - b;
  assign sub_borrow = (a < b);
  assign add_v      = (a[DATA_W-1] == b[DATA_W-1]) && (add_full[DATA_W-1] != a[DATA_W-1]);
  assign sub_v      = (a[DATA_W-1] != b[DATA_W-1]) && (sub_res[DATA_W-1] != a[DATA_W-1]);

`ifdef ALU_MUL_EN
  logic [DATA_W-1:0] mul_lo;
  assign mul_lo = a * b;
`endif

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op)
      OP_REG, OP_IMM: begin
        case (func4)
          ALU_ADD: begin
            res   = add_full[DATA_W-1:0];
            res_c = add_full[DATA_W];
            res_v = add_v;
          end
          ALU_SUB: begin
            res   = sub_res;
            res_c = sub_borrow;
            res_v = sub_v;
          end
          ALU_INV: res = ~a;
          ALU_SLL: res = a << b[3:0];
          ALU_SRL: res = a >> b[3:0];
          ALU_AND: res = a & b;
          ALU_OR:  res = a | b;
          ALU_SLT: res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_MUL_EN
          ALU_MUL: res = mul_lo;
`endif
          default: res = '0;
        endcase
      end
      OP_ADDR: begin
        res   = add_full[DATA_W-1:0];
        res_c = add_full[DATA_W];
        res_v = add_v;
      end
      OP_UPPER: res = {imm, {(DATA_W-IMM_W){1'b0}}};
      default:  res = '0;
    endcase
  end

  always_comb begin
    flags_nxt   = '0;
    flags_nxt.z = (res == '0);
    flags_nxt.n = res[DATA_W-1];
    flags_nxt.c = res_c;
    flags_nxt.v = res_v;
  end

  alu_flags u_flags (
    .clk       (clk),
    .rst       (rst),
    .flag_we   (flag_we),
    .flags_nxt (flags_nxt),
    .flags_o   (flags_cur)
  );

  assign alu_o  = res;
  assign flag_z = flags_cur.z;
  assign flag_n = flags_cur.n;
  assign flag_c = flags_cur.c;
  assign flag_v = flags_cur.v;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: combinational results and registered Z/N/C/V flags.
module tb_alu;

  logic        clk;
  logic        rst;
  logic        flag_we;
  logic [15:0] rs1_data;
  logic [15:0] rs2_data;
  logic [5:0]  imm;
  logic [2:0]  op;
  logic [3:0]  func4;
  logic [15:0] alu_o;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic        flag_v;

  int checks;
  int errors;

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .flag_we  (flag_we),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .imm      (imm),
    .op       (op),
    .func4    (func4),
    .alu_o    (alu_o),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_c   (flag_c),
    .flag_v   (flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one ALU operation and let the combinational result settle.
  task automatic drive(input logic [2:0] o, input logic [3:0] f,
                       input logic [15:0] r1, input logic [15:0] r2, input logic [5:0] im);
    op = o; func4 = f; rs1_data = r1; rs2_data = r2; imm = im;
    #1;
  endtask

  task automatic pulse_we();
    flag_we = 1'b1;
    @(posedge clk);
    #1;
    flag_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {flag_z, flag_n, flag_c, flag_v});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    drive(3'd0, 4'd0, 16'd3, 16'd3, 6'd0);
    checks++;
    if (alu_o !== 16'd6) begin
      errors++;
      $display("FAIL add_3_3: got %h expected 0006", alu_o);
    end
    pulse_we();
    checks++;
    if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0000) begin
      errors++;
      $display("FAIL add_flags: got %b expected 0000", {flag_z, flag_n, flag_c, flag_v});
    end
  endtask

  task automatic test_sub();
    drive(3'd0, 4'd1, 16'd5, 16'd4, 6'd0);
    checks++;
    if (alu_o !== 16'd1) begin
      errors++;
      $display("FAIL sub_5_4: got %h expected 0001", alu_o);
    end
    drive(3'd0, 4'd1, 16'd4, 16'd5, 6'd0);
    checks++;
    if (alu_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL sub_4_5: got %h expected ffff", alu_o);
    end
    pulse_we();
    checks++;
    if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0110) begin
      errors++;
      $display("FAIL sub_borrow_flags: got %b expected 0110", {flag_z, flag_n, flag_c, flag_v});
    end
    // 0x8000 - 1 overflows to a positive result with no borrow.
    drive(3'd0, 4'd1, 16'h8000, 16'd1, 6'd0);
    pulse_we();
    checks++;
    if (alu_o !== 16'h7FFF || {flag_z, flag_n, flag_c, flag_v} !== 4'b0001) begin
      errors++;
      $display("FAIL sub_overflow: got %h/%b expected 7fff/0001", alu_o,
               {flag_z, flag_n, flag_c, flag_v});
    end
  endtask

  task automatic test_inv();
    drive(3'd0, 4'd2, 16'd2, 16'hABCD, 6'd0);
    checks++;
    if (alu_o !== 16'd65533) begin
      errors++;
      $display("FAIL inv_2: got %0d expected 65533", alu_o);
    end
    drive(3'd0, 4'd2, 16'd0, 16'd0, 6'd0);
    pulse_we();
    checks++;
    if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0100) begin
      errors++;
      $display("FAIL inv_flags: got %b expected 0100", {flag_z, flag_n, flag_c, flag_v});
    end
  endtask

  task automatic test_shift_logic();
    drive(3'd0, 4'd3, 16'd1, 16'd15, 6'd0);
    checks++;
    if (alu_o !== 16'h8000) begin
      errors++;
      $display("FAIL sll_15: got %h expected 8000", alu_o);
    end
    drive(3'd0, 4'd4, 16'h8000, 16'd15, 6'd0);
    checks++;
    if (alu_o !== 16'h0001) begin
      errors++;
      $display("FAIL srl_15: got %h expected 0001", alu_o);
    end
    drive(3'd0, 4'd3, 16'h1234, 16'hFFF0, 6'd0);
    checks++;
    if (alu_o !== 16'h1234) begin
      errors++;
      $display("FAIL sll_amt0_upper_ignored: got %h expected 1234", alu_o);
    end
    drive(3'd0, 4'd4, 16'hF000, 16'h0014, 6'd0);
    checks++;
    if (alu_o !== 16'h0F00) begin
      errors++;
      $display("FAIL srl_amt4: got %h expected 0f00", alu_o);
    end
    drive(3'd0, 4'd5, 16'hF0F0, 16'h0FF0, 6'd0);
    checks++;
    if (alu_o !== 16'h00F0) begin
      errors++;
      $display("FAIL and: got %h expected 00f0", alu_o);
    end
    drive(3'd0, 4'd6, 16'hF0F0, 16'h0FF0, 6'd0);
    checks++;
    if (alu_o !== 16'hFFF0) begin
      errors++;
      $display("FAIL or: got %h expected fff0", alu_o);
    end
  endtask

  task automatic test_slt();
    drive(3'd0, 4'd7, 16'hFFFF, 16'd1, 6'd0);
    checks++;
    if (alu_o !== 16'd1) begin
      errors++;
      $display("FAIL slt_neg_lt_pos: got %h expected 0001", alu_o);
    end
    drive(3'd0, 4'd7, 16'd1, 16'hFFFF, 6'd0);
    checks++;
    if (alu_o !== 16'd0) begin
      errors++;
      $display("FAIL slt_pos_lt_neg: got %h expected 0000", alu_o);
    end
  endtask

  task automatic test_imm();
    drive(3'd1, 4'd0, 16'd10, 16'hFFFF, 6'b111111);
    checks++;
    if (alu_o !== 16'd9) begin
      errors++;
      $display("FAIL imm_add_neg1: got %h expected 0009", alu_o);
    end
    drive(3'd2, 4'd5, 16'h0100, 16'h0000, 6'h3E);
    checks++;
    if (alu_o !== 16'h00FE) begin
      errors++;
      $display("FAIL addr_mode: got %h expected 00fe", alu_o);
    end
    drive(3'd3, 4'd0, 16'h1234, 16'h5678, 6'd1);
    checks++;
    if (alu_o !== 16'h0400) begin
      errors++;
      $display("FAIL upper_1: got %h expected 0400", alu_o);
    end
    drive(3'd3, 4'd1, 16'h0000, 16'h0000, 6'h3F);
    checks++;
    if (alu_o !== 16'hFC00) begin
      errors++;
      $display("FAIL upper_3f: got %h expected fc00", alu_o);
    end
    drive(3'd5, 4'd0, 16'h1111, 16'h2222, 6'h05);
    checks++;
    if (alu_o !== 16'h0000) begin
      errors++;
      $display("FAIL reserved_op: got %h expected 0000", alu_o);
    end
  endtask

  task automatic test_reserved_func();
    logic [15:0] exp_mul;
`ifdef ALU_MUL_EN
    exp_mul = 16'd15;
`else
    exp_mul = 16'd0;
`endif
    drive(3'd0, 4'd8, 16'd3, 16'd5, 6'd0);
    checks++;
    if (alu_o !== exp_mul) begin
      errors++;
      $display("FAIL func8: got %h expected %h", alu_o, exp_mul);
    end
    drive(3'd0, 4'd9, 16'd3, 16'd5, 6'd0);
    checks++;
    if (alu_o !== 16'd0) begin
      errors++;
      $display("FAIL func9: got %h expected 0000", alu_o);
    end
  endtask

  task automatic test_flag_boundaries();
    drive(3'd0, 4'd0, 16'hFFFF, 16'd1, 6'd0);
    pulse_we();
    checks++;
    if (alu_o !== 16'h0000 || {flag_z, flag_n, flag_c, flag_v} !== 4'b1010) begin
      errors++;
      $display("FAIL add_ffff_1: got %h/%b expected 0000/1010", alu_o,
               {flag_z, flag_n, flag_c, flag_v});
    end
    drive(3'd0, 4'd0, 16'h7FFF, 16'd1, 6'd0);
    pulse_we();
    checks++;
    if (alu_o !== 16'h8000 || {flag_z, flag_n, flag_c, flag_v} !== 4'b0101) begin
      errors++;
      $display("FAIL add_7fff_1: got %h/%b expected 8000/0101", alu_o,
               {flag_z, flag_n, flag_c, flag_v});
    end
  endtask

  task automatic test_hold();
    drive(3'd0, 4'd0, 16'd0, 16'd0, 6'd0);
    flag_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0101) begin
      errors++;
      $display("FAIL flags_hold: got %b expected 0101", {flag_z, flag_n, flag_c, flag_v});
    end
  endtask

  task automatic test_async_reset();
    drive(3'd0, 4'd0, 16'h7FFF, 16'd1, 6'd0);
    pulse_we();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got %b expected 0000", {flag_z, flag_n, flag_c, flag_v});
    end
    checks++;
    if (alu_o !== 16'h8000) begin
      errors++;
      $display("FAIL alu_during_reset: got %h expected 8000", alu_o);
    end
    flag_we = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_over_we: got %b expected 0000", {flag_z, flag_n, flag_c, flag_v});
    end
    flag_we = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    flag_we = 1'b0;
    op = 3'd0; func4 = 4'd0; rs1_data = 16'd0; rs2_data = 16'd0; imm = 6'd0;
    test_reset();
    test_add();
    test_sub();
    test_inv();
    test_shift_logic();
    test_slt();
    test_imm();
    test_reserved_func();
    test_flag_boundaries();
    test_hold();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
